// File: rtl/bike_pkg.sv
// Shared definitions for the bike computer wheel-size editor: FSM state
// encoding, BCD digit type, accepted circumference window, default blink
// half-period and a BCD conversion helper for reset constants.
package bike_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EDIT    = 2'd1,
    CONVERT = 2'd2
  } state_t;

  typedef logic [3:0] bcd_t;

  // Plausible circumference window in mm (used when the limit check is built in)
  localparam int WHEEL_MIN          = 1000;
  localparam int WHEEL_MAX          = 3000;
  // 200 ms at a 12.8 kHz system clock
  localparam int BLINK_HALF_DEFAULT = 2560;

  // Split a 0..9999 value into four packed BCD digits, thousands in [15:12].
  function automatic logic [15:0] to_bcd4(input int v);
    logic [15:0] r;
    r[15:12] = 4'((v / 1000) % 10);
    r[11:8]  = 4'((v / 100) % 10);
    r[7:4]   = 4'((v / 10) % 10);
    r[3:0]   = 4'(v % 10);
    return r;
  endfunction

endpackage

// File: rtl/wheelsize_editor_bcd2bin.sv
// bcd2bin: four-digit BCD to binary converter, one multiply-add per cycle,
// thousands digit first. A start pulse begins a conversion; done is high in
// the fourth cycle together with the final value. The digit input is read
// live, so it must stay stable while the conversion runs.
module bcd2bin
  import bike_pkg::*;
(
  input  logic        Clock,
  input  logic        nReset,
  input  logic        start,
  input  logic [15:0] digits,
  output logic        done,
  output logic [13:0] value
);

  logic        busy_reg;
  logic [1:0]  idx_reg;
  logic [13:0] acc_reg;
  bcd_t        cur_digit;
  logic [13:0] step;

  // Select the digit for this step: idx 0 is thousands, 3 is units
  always_comb begin
    cur_digit = 4'd0;
    case (idx_reg)
      2'd0: cur_digit = digits[15:12];
      2'd1: cur_digit = digits[11:8];
      2'd2: cur_digit = digits[7:4];
      2'd3: cur_digit = digits[3:0];
      default: cur_digit = 4'd0;
    endcase
  end

  // acc never exceeds 999 before the last step, so 14 bits cannot overflow
  assign step  = (acc_reg * 14'd10) + {10'd0, cur_digit};
  assign done  = busy_reg && (idx_reg == 2'd3);
  assign value = step;

  // Step counter and accumulator
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      busy_reg <= 1'b0;
      idx_reg  <= 2'd0;
      acc_reg  <= 14'd0;
    end else if (start) begin
      busy_reg <= 1'b1;
      idx_reg  <= 2'd0;
      acc_reg  <= 14'd0;
    end else if (busy_reg) begin
      acc_reg <= step;
      idx_reg <= idx_reg + 2'd1;
      if (idx_reg == 2'd3)
        busy_reg <= 1'b0;
    end
  end

endmodule

// File: rtl/wheelsize_editor.sv
// wheelsize_editor: four-digit BCD wheel circumference editor driven by two
// push-button pulses, with cursor blink and BCD-to-binary commit.
// Build option: define WHEEL_LIMIT_EN to reject circumferences outside
// WHEEL_MIN..WHEEL_MAX (wheel_err pulses instead of wheel_valid).
module wheelsize_editor
  import bike_pkg::*;
#(
  parameter int DEFAULT_WHEEL = 2136,
  parameter int BLINK_HALF    = BLINK_HALF_DEFAULT
) (
  input  logic        Clock,
  input  logic        nReset,
  input  logic        wheelsize_menu,
  input  logic        wheelsize_digit_change,
  input  logic        wheelsize_value_change,
  output logic [15:0] edit_digits,
  output logic [1:0]  cursor,
  output logic        blink,
  output logic [13:0] wheel_circ,
  output logic        wheel_valid,
  output logic        wheel_err
);

  localparam logic [15:0]       DEFAULT_BCD  = to_bcd4(DEFAULT_WHEEL);
  localparam logic [13:0]       DEFAULT_CIRC = 14'(DEFAULT_WHEEL);
  localparam int                CNT_W        = $clog2(BLINK_HALF + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST     = CNT_W'(BLINK_HALF - 1);

  state_t            state_reg, state_next;
  logic [15:0]       buf_reg, buf_upd, committed_reg;
  logic [1:0]        cursor_reg;
  logic              blink_reg;
  logic [CNT_W-1:0]  blink_cnt_reg;
  logic [13:0]       circ_reg;
  logic              valid_reg;
  logic              edit_active, load_buf, conv_start, commit, show_buf, any_pulse;
  logic              conv_done;
  logic [13:0]       conv_value;

  // State register
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) state_reg <= IDLE;
    else         state_reg <= state_next;
  end

  // Next-state logic; menu changes during CONVERT wait until IDLE
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (wheelsize_menu)  state_next = EDIT;
      EDIT:    if (!wheelsize_menu) state_next = CONVERT;
      CONVERT: if (conv_done)       state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State-decoded controls
  always_comb begin
    edit_active = 1'b0;
    load_buf    = 1'b0;
    conv_start  = 1'b0;
    commit      = 1'b0;
    show_buf    = 1'b0;
    case (state_reg)
      IDLE:    load_buf = wheelsize_menu;
      EDIT: begin
        edit_active = 1'b1;
        conv_start  = !wheelsize_menu;
        show_buf    = 1'b1;
      end
      CONVERT: begin
        commit   = conv_done;
        show_buf = 1'b1;
      end
      default: ;
    endcase
  end

  assign any_pulse = wheelsize_digit_change || wheelsize_value_change;

  // Per-digit increment with 9 -> 0 wrap; cursor 0 addresses digit 3 (thousands)
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_digit
      bcd_t d;
      logic hit;
      assign d   = buf_reg[gi*4 +: 4];
      assign hit = edit_active && wheelsize_value_change && (cursor_reg == 2'(3 - gi));
      assign buf_upd[gi*4 +: 4] = hit ? ((d == 4'd9) ? 4'd0 : d + 4'd1) : d;
    end
  endgenerate

  // Edit buffer and cursor: increment uses the old cursor, then cursor advances
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      buf_reg    <= DEFAULT_BCD;
      cursor_reg <= 2'd0;
    end else if (load_buf) begin
      buf_reg    <= committed_reg;
      cursor_reg <= 2'd0;
    end else if (edit_active) begin
      buf_reg <= buf_upd;
      if (wheelsize_digit_change)
        cursor_reg <= cursor_reg + 2'd1;
    end
  end

  // Cursor blink: runs only while editing; a pulse restarts it with the digit shown
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      blink_reg     <= 1'b0;
      blink_cnt_reg <= '0;
    end else if (load_buf) begin
      blink_reg     <= 1'b1;
      blink_cnt_reg <= '0;
    end else if (edit_active && wheelsize_menu) begin
      if (any_pulse) begin
        blink_reg     <= 1'b1;
        blink_cnt_reg <= '0;
      end else if (blink_cnt_reg == CNT_LAST) begin
        blink_reg     <= ~blink_reg;
        blink_cnt_reg <= '0;
      end else begin
        blink_cnt_reg <= blink_cnt_reg + 1'b1;
      end
    end else begin
      blink_reg     <= 1'b0;
      blink_cnt_reg <= '0;
    end
  end

  bcd2bin u_conv (
    .Clock  (Clock),
    .nReset (nReset),
    .start  (conv_start),
    .digits (buf_reg),
    .done   (conv_done),
    .value  (conv_value)
  );

`ifdef WHEEL_LIMIT_EN
  logic err_reg;

  // Commit in-range results; out-of-range ones leave the stored value alone
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      circ_reg      <= DEFAULT_CIRC;
      committed_reg <= DEFAULT_BCD;
      valid_reg     <= 1'b0;
      err_reg       <= 1'b0;
    end else begin
      valid_reg <= 1'b0;
      err_reg   <= 1'b0;
      if (commit) begin
        if ((conv_value < 14'(WHEEL_MIN)) || (conv_value > 14'(WHEEL_MAX))) begin
          err_reg <= 1'b1;
        end else begin
          circ_reg      <= conv_value;
          committed_reg <= buf_reg;
          valid_reg     <= 1'b1;
        end
      end
    end
  end

  assign wheel_err = err_reg;
`else
  // Commit every converted result
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      circ_reg      <= DEFAULT_CIRC;
      committed_reg <= DEFAULT_BCD;
      valid_reg     <= 1'b0;
    end else begin
      valid_reg <= 1'b0;
      if (commit) begin
        circ_reg      <= conv_value;
        committed_reg <= buf_reg;
        valid_reg     <= 1'b1;
      end
    end
  end

  assign wheel_err = 1'b0;
`endif

  assign edit_digits = show_buf ? buf_reg : committed_reg;
  assign cursor      = cursor_reg;
  assign blink       = blink_reg;
  assign wheel_circ  = circ_reg;
  assign wheel_valid = valid_reg;

endmodule

// File: tb/tb_wheelsize_editor.sv
// Testbench for wheelsize_editor. Stimulus queues expected display snapshots
// and expected commit pulses; a negedge monitor compares them.
module tb_wheelsize_editor;

  logic        Clock = 1'b0;
  logic        nReset;
  logic        wheelsize_menu;
  logic        wheelsize_digit_change;
  logic        wheelsize_value_change;
  logic [15:0] edit_digits;
  logic [1:0]  cursor;
  logic        blink;
  logic [13:0] wheel_circ;
  logic        wheel_valid;
  logic        wheel_err;

  wheelsize_editor dut (
    .Clock                  (Clock),
    .nReset                 (nReset),
    .wheelsize_menu         (wheelsize_menu),
    .wheelsize_digit_change (wheelsize_digit_change),
    .wheelsize_value_change (wheelsize_value_change),
    .edit_digits            (edit_digits),
    .cursor                 (cursor),
    .blink                  (blink),
    .wheel_circ             (wheel_circ),
    .wheel_valid            (wheel_valid),
    .wheel_err              (wheel_err)
  );

  always #5 Clock = ~Clock;

  // Hand-computed expectations for the directed sequence
`ifdef WHEEL_LIMIT_EN
  localparam bit          S2_ERR   = 1'b1;
  localparam logic [15:0] C2_DIG   = 16'h2136;
  localparam logic [13:0] C2_CIRC  = 14'd2136;
  localparam logic [15:0] S3_ENTER = 16'h2136;
  localparam logic [15:0] S3_BOTH  = 16'h2137;
  localparam logic [15:0] S3_FALL  = 16'h3137;
  localparam bit          S3_ERR   = 1'b1;
  localparam logic [15:0] S3_DIG   = 16'h2136;
  localparam logic [13:0] S3_CIRC  = 14'd2136;
  localparam bit          B_ERR    = 1'b1;
  localparam logic [15:0] B_DIG    = 16'h2136;
  localparam logic [13:0] B_CIRC   = 14'd2136;
`else
  localparam bit          S2_ERR   = 1'b0;
  localparam logic [15:0] C2_DIG   = 16'h5036;
  localparam logic [13:0] C2_CIRC  = 14'd5036;
  localparam logic [15:0] S3_ENTER = 16'h5036;
  localparam logic [15:0] S3_BOTH  = 16'h5037;
  localparam logic [15:0] S3_FALL  = 16'h6037;
  localparam bit          S3_ERR   = 1'b0;
  localparam logic [15:0] S3_DIG   = 16'h6037;
  localparam logic [13:0] S3_CIRC  = 14'd6037;
  localparam bit          B_ERR    = 1'b0;
  localparam logic [15:0] B_DIG    = 16'h0500;
  localparam logic [13:0] B_CIRC   = 14'd500;
`endif

  typedef struct packed {
    int          cyc;
    logic [15:0] digits;
    logic [1:0]  cur;
    logic        blk;
    logic [13:0] circ;
  } probe_t;

  typedef struct packed {
    int          cyc;
    logic        err;
    logic [13:0] circ;
  } commit_t;

  probe_t  probe_q[$];
  string   name_q[$];
  commit_t commit_q[$];

  int cyc = 0;
  int n_vec = 0;
  int n_err = 0;

  always @(posedge Clock) cyc <= cyc + 1;

  // Monitor: snapshot checks at their cycle, commit pulses whenever they appear
  probe_t  mp;
  commit_t mc;
  string   mn;
  always @(negedge Clock) begin
    while (probe_q.size() > 0 && probe_q[0].cyc <= cyc) begin
      mp = probe_q.pop_front();
      mn = name_q.pop_front();
      n_vec++;
      if (mp.cyc != cyc || edit_digits !== mp.digits || cursor !== mp.cur ||
          blink !== mp.blk || wheel_circ !== mp.circ) begin
        n_err++;
        $display("FAIL %s @%0d: digits=%h cursor=%0d blink=%b circ=%0d, required digits=%h cursor=%0d blink=%b circ=%0d",
                 mn, cyc, edit_digits, cursor, blink, wheel_circ, mp.digits, mp.cur, mp.blk, mp.circ);
      end else begin
        $display("probe %s @%0d ok: digits=%h cursor=%0d blink=%b circ=%0d",
                 mn, cyc, edit_digits, cursor, blink, wheel_circ);
      end
    end
    if (wheel_valid || wheel_err) begin
      n_vec++;
      if (commit_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_pulse @%0d: valid=%b err=%b circ=%0d, required no pulse",
                 cyc, wheel_valid, wheel_err, wheel_circ);
      end else begin
        mc = commit_q.pop_front();
        if (mc.cyc != cyc || wheel_err !== mc.err || wheel_valid !== !mc.err ||
            wheel_circ !== mc.circ) begin
          n_err++;
          $display("FAIL commit @%0d: valid=%b err=%b circ=%0d, required @%0d valid=%b err=%b circ=%0d",
                   cyc, wheel_valid, wheel_err, wheel_circ, mc.cyc, !mc.err, mc.err, mc.circ);
        end else begin
          $display("commit @%0d ok: valid=%b err=%b circ=%0d", cyc, wheel_valid, wheel_err, wheel_circ);
        end
      end
    end else if (commit_q.size() > 0 && cyc > commit_q[0].cyc) begin
      mc = commit_q.pop_front();
      n_vec++;
      n_err++;
      $display("FAIL commit_missing @%0d: no pulse, required @%0d err=%b circ=%0d",
               cyc, mc.cyc, mc.err, mc.circ);
    end
  end

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic probe(input string nm, input logic [15:0] d, input logic [1:0] c,
                       input logic b, input logic [13:0] w);
    probe_t p;
    p.cyc    = cyc;
    p.digits = d;
    p.cur    = c;
    p.blk    = b;
    p.circ   = w;
    probe_q.push_back(p);
    name_q.push_back(nm);
  endtask

  // Expect the commit pulse 5 cycles after the menu falls (call as menu drops)
  task automatic expect_commit(input logic e, input logic [13:0] w);
    commit_t c;
    c.cyc  = cyc + 5;
    c.err  = e;
    c.circ = w;
    commit_q.push_back(c);
  endtask

  task automatic pulse(input logic v, input logic d);
    wheelsize_value_change = v;
    wheelsize_digit_change = d;
    tick();
    wheelsize_value_change = 1'b0;
    wheelsize_digit_change = 1'b0;
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) tick();
  endtask

  task automatic set_digit(input logic [3:0] from, input logic [3:0] to);
    int n;
    n = (int'(to) - int'(from) + 10) % 10;
    repeat (n) pulse(1'b1, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int e;
  logic [15:0] bs;

  initial begin
    nReset = 1'b0;
    wheelsize_menu = 1'b0;
    wheelsize_digit_change = 1'b0;
    wheelsize_value_change = 1'b0;
    repeat (3) tick();
    nReset = 1'b1;
    tick();
    tick();
    probe("reset", 16'h2136, 2'd0, 1'b0, 14'd2136);
    pulse(1'b1, 1'b1);
    probe("idle_ignore", 16'h2136, 2'd0, 1'b0, 14'd2136);

    // Edit entry, thousands 2->5, hundreds 1->0 with wrap
    wheelsize_menu = 1'b1;
    tick();
    probe("enter", 16'h2136, 2'd0, 1'b1, 14'd2136);
    repeat (3) pulse(1'b1, 1'b0);
    probe("thousands", 16'h5136, 2'd0, 1'b1, 14'd2136);
    pulse(1'b0, 1'b1);
    probe("cursor1", 16'h5136, 2'd1, 1'b1, 14'd2136);
    repeat (9) pulse(1'b1, 1'b0);
    probe("hund_wrap", 16'h5036, 2'd1, 1'b1, 14'd2136);
    wheelsize_menu = 1'b0;
    expect_commit(S2_ERR, C2_CIRC);
    tick();
    tick();
    probe("convert_show", 16'h5036, 2'd1, 1'b0, 14'd2136);
    repeat (3) tick();
    probe("commit1_idle", C2_DIG, 2'd1, 1'b0, C2_CIRC);

    // Simultaneous pulses at cursor 3, pulse on the menu-fall cycle, menu held off
    wheelsize_menu = 1'b1;
    tick();
    probe("enter2", S3_ENTER, 2'd0, 1'b1, C2_CIRC);
    repeat (3) pulse(1'b0, 1'b1);
    probe("cursor3", S3_ENTER, 2'd3, 1'b1, C2_CIRC);
    pulse(1'b1, 1'b1);
    probe("both_pulses", S3_BOTH, 2'd0, 1'b1, C2_CIRC);
    wheelsize_menu = 1'b0;
    wheelsize_value_change = 1'b1;
    expect_commit(S3_ERR, S3_CIRC);
    tick();
    wheelsize_value_change = 1'b0;
    probe("fall_pulse", S3_FALL, 2'd0, 1'b0, C2_CIRC);
    pulse(1'b1, 1'b1);
    wheelsize_menu = 1'b1;
    tick();
    probe("convert_ignore", S3_FALL, 2'd0, 1'b0, C2_CIRC);
    tick();
    tick();
    probe("commit2_idle", S3_DIG, 2'd0, 1'b0, S3_CIRC);
    tick();
    probe("reenter", S3_DIG, 2'd0, 1'b1, S3_CIRC);

    // Blink free-running: toggles after 2560 cycles in EDIT
    e = cyc;
    wait_until(e + 2559);
    probe("blink_hold", S3_DIG, 2'd0, 1'b1, S3_CIRC);
    tick();
    probe("blink_toggle", S3_DIG, 2'd0, 1'b0, S3_CIRC);
    wheelsize_menu = 1'b0;
    expect_commit(1'b0, S3_DIG == 16'h6037 ? 14'd6037 : 14'd2136);
    repeat (5) tick();
    probe("commitA_idle", S3_DIG, 2'd0, 1'b0, S3_DIG == 16'h6037 ? 14'd6037 : 14'd2136);

    // Blink restart on a pulse at cycle 1000; next toggle at 3560
    wheelsize_menu = 1'b1;
    tick();
    e = cyc;
    probe("enterB", S3_DIG, 2'd0, 1'b1, S3_CIRC);
    wait_until(e + 999);
    pulse(1'b0, 1'b1);
    probe("blink_pulse", S3_DIG, 2'd1, 1'b1, S3_CIRC);
    wait_until(e + 2560);
    probe("blink_kept", S3_DIG, 2'd1, 1'b1, S3_CIRC);
    wait_until(e + 3559);
    probe("blink_3559", S3_DIG, 2'd1, 1'b1, S3_CIRC);
    tick();
    probe("blink_3560", S3_DIG, 2'd1, 1'b0, S3_CIRC);

    // Edit to 0500: rejected with the limit check, committed without it
    bs = S3_DIG;
    set_digit(bs[11:8], 4'd5);
    pulse(1'b0, 1'b1);
    set_digit(bs[7:4], 4'd0);
    pulse(1'b0, 1'b1);
    set_digit(bs[3:0], 4'd0);
    pulse(1'b0, 1'b1);
    set_digit(bs[15:12], 4'd0);
    probe("edit0500", 16'h0500, 2'd0, 1'b1, S3_CIRC);
    wheelsize_menu = 1'b0;
    expect_commit(B_ERR, B_CIRC);
    repeat (5) tick();
    probe("commitB_idle", B_DIG, 2'd0, 1'b0, B_CIRC);

    // Asynchronous reset in the middle of CONVERT: no pulse, defaults restored
    wheelsize_menu = 1'b1;
    tick();
    pulse(1'b1, 1'b0);
    wheelsize_menu = 1'b0;
    tick();
    tick();
    nReset = 1'b0;
    probe("async_reset", 16'h2136, 2'd0, 1'b0, 14'd2136);
    repeat (8) tick();
    nReset = 1'b1;
    tick();
    probe("post_reset", 16'h2136, 2'd0, 1'b0, 14'd2136);
    repeat (4) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
